// File: rtl/apb_periph_pkg.sv
// Shared types and region map for the peripheral APB bridge.
// Imported by the bridge top and its wait timer.
package apb_periph_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } state_e;

   localparam logic [3:0] REG_I2C  = 4'h0;
   localparam logic [3:0] REG_SPI  = 4'h1;
   localparam logic [3:0] REG_GPIO = 4'h2;
   localparam logic [3:0] REG_INT  = 4'h4;

   localparam logic [15:0] SLV_REGION_DEF =
      {REG_INT, REG_GPIO, REG_SPI, REG_I2C};

endpackage

// File: rtl/apb_wait_timer.sv
// Bounded ACCESS-phase wait counter for the APB bridge.
// Cleared before ACCESS, counts each ACCESS cycle, flags the last allowed one.
module apb_wait_timer
   import apb_periph_pkg::*;
#(
   parameter int TIMEOUT_CYC = 256
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic inc_i,
   output logic expired_o
);

   localparam int CW = $clog2(TIMEOUT_CYC);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expired_o = (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/apb_periph_bridge.sv
// Single-master APB3 bridge to the I2C, SPI, GPIO and interrupt slaves.
// Decodes paddr[11:8], re-times SETUP/ACCESS and registers one response.
module apb_periph_bridge
   import apb_periph_pkg::*;
#(
   parameter int APB_AW      = 12,
   parameter int APB_DW      = 32,
   parameter int NUM_SLV     = 4,
   parameter logic [4*NUM_SLV-1:0] SLV_REGION = SLV_REGION_DEF,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                      clk_apb,
   input  logic                      rst_apb,
   input  logic [APB_AW-1:0]         paddr,
   input  logic                      pwrite,
   input  logic [APB_DW-1:0]         pwdata,
   input  logic                      psel,
   input  logic                      penable,
   output logic [APB_DW-1:0]         prdata,
   output logic                      pready,
   output logic                      pslverr,
   output logic [NUM_SLV-1:0]        psel_s,
   output logic                      penable_s,
   output logic [APB_AW-1:0]         paddr_s,
   output logic                      pwrite_s,
   output logic [APB_DW-1:0]         pwdata_s,
   input  logic [NUM_SLV*APB_DW-1:0] prdata_s,
   input  logic [NUM_SLV-1:0]        pready_s,
   input  logic [NUM_SLV-1:0]        pslverr_s,
   output logic                      timeout_evt,
   output logic [3:0]                err_region
);

   // Scan high to low so the lowest matching slave index wins.
   function automatic logic [NUM_SLV-1:0] dec(input logic [3:0] r);
      logic [NUM_SLV-1:0] oh;
      oh = '0;
      for (int k = NUM_SLV - 1; k >= 0; k--) begin
         if (SLV_REGION[4*k +: 4] == r) begin
            oh    = '0;
            oh[k] = 1'b1;
         end
      end
      return oh;
   endfunction

   state_e              state_q, state_d;
   logic [APB_AW-1:0]   addr_q, addr_d;
   logic                wr_q, wr_d;
   logic [APB_DW-1:0]   wdata_q, wdata_d;
   logic [NUM_SLV-1:0]  sel_q, sel_d;
   logic                abort_q, abort_d;
   logic [APB_DW-1:0]   prdata_q, prdata_d;
   logic                pready_q, pready_d;
   logic                perr_q, perr_d;
   logic                tmo_q, tmo_d;
   logic [3:0]          ereg_q, ereg_d;

   logic [NUM_SLV-1:0]  hit;
   logic                s_rdy, s_err;
   logic [APB_DW-1:0]   s_rd;
   logic                t_clr, t_inc, t_exp;
   logic                resp_ok;

   assign hit = dec(paddr[11:8]);

   always_comb begin
      s_rdy = 1'b0;
      s_err = 1'b0;
      s_rd  = '0;
      for (int k = 0; k < NUM_SLV; k++) begin
         if (sel_q[k]) begin
            s_rdy = s_rdy | pready_s[k];
            s_err = s_err | pslverr_s[k];
            s_rd  = s_rd | prdata_s[k*APB_DW +: APB_DW];
         end
      end
   end

   apb_wait_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_tmr (
      .clk_i     (clk_apb),
      .rst_i     (rst_apb),
      .clr_i     (t_clr),
      .inc_i     (t_inc),
      .expired_o (t_exp)
   );

   // A master that dropped psel mid-transfer gets no pready at all.
   assign resp_ok = psel & ~abort_q;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wr_d     = wr_q;
      wdata_d  = wdata_q;
      sel_d    = sel_q;
      abort_d  = abort_q;
      prdata_d = '0;
      pready_d = 1'b0;
      perr_d   = 1'b0;
      tmo_d    = 1'b0;
      ereg_d   = ereg_q;
      t_clr    = 1'b0;
      t_inc    = 1'b0;
      unique case (state_q)
         IDLE: begin
            abort_d = 1'b0;
            if (psel && !penable) begin
               addr_d  = paddr;
               wr_d    = pwrite;
               wdata_d = pwdata;
               sel_d   = hit;
               if (|hit) begin
                  state_d = SETUP;
               end else begin
                  state_d  = RESP;
                  pready_d = 1'b1;
                  perr_d   = 1'b1;
               end
            end
         end
         SETUP: begin
            t_clr = 1'b1;
            if (!psel)
               abort_d = 1'b1;
            state_d = ACCESS;
         end
         ACCESS: begin
            t_inc = 1'b1;
            if (!psel)
               abort_d = 1'b1;
            if (s_rdy) begin
               state_d  = RESP;
               pready_d = resp_ok;
               perr_d   = resp_ok & s_err;
               if (resp_ok && !wr_q && !s_err)
                  prdata_d = s_rd;
            end else if (t_exp) begin
               state_d  = RESP;
               pready_d = resp_ok;
               perr_d   = resp_ok;
               tmo_d    = 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
            if (perr_q)
               ereg_d = addr_q[11:8];
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_apb or posedge rst_apb) begin
      if (rst_apb) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wr_q     <= 1'b0;
         wdata_q  <= '0;
         sel_q    <= '0;
         abort_q  <= 1'b0;
         prdata_q <= '0;
         pready_q <= 1'b0;
         perr_q   <= 1'b0;
         tmo_q    <= 1'b0;
         ereg_q   <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wr_q     <= wr_d;
         wdata_q  <= wdata_d;
         sel_q    <= sel_d;
         abort_q  <= abort_d;
         prdata_q <= prdata_d;
         pready_q <= pready_d;
         perr_q   <= perr_d;
         tmo_q    <= tmo_d;
         ereg_q   <= ereg_d;
      end
   end

   assign psel_s      = (state_q == SETUP || state_q == ACCESS) ? sel_q : '0;
   assign penable_s   = (state_q == ACCESS);
   assign paddr_s     = addr_q;
   assign pwrite_s    = wr_q;
   assign pwdata_s    = wdata_q;
   assign prdata      = prdata_q;
   assign pready      = pready_q;
   assign pslverr     = perr_q;
   assign timeout_evt = tmo_q;
   assign err_region  = ereg_q;

endmodule
